// File: rtl/helios_sched_pkg.sv
// rtl/helios_sched_pkg.sv - Shared types and sizing helpers for the decoder round scheduler
package helios_sched_pkg;

   localparam int ITER_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      REPORT
   } sched_state_t;

   typedef struct packed {
      logic [31:0]       test_id;
      logic [31:0]       cycles;
      logic [ITER_W-1:0] iterations;
      logic              timeout;
   } sched_report_t;

   function automatic int layer_bits(input int dist_x, input int dist_z);
      return dist_x * dist_z;
   endfunction

   function automatic int pu_count(input int dist_x, input int dist_z, input int rounds);
      return dist_x * dist_z * rounds;
   endfunction

endpackage

// File: rtl/latency_stats_accumulator.sv
// rtl/latency_stats_accumulator.sv - Accepted-report counter and non-timeout latency sum
// A clear coinciding with an accept wins, so the accumulate of that report is dropped.
module latency_stats_accumulator (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic        timeout_i,
   input  logic [31:0] cycles_i,
   output logic [31:0] test_count_o,
   output logic [63:0] total_latency_o
);

   logic [31:0] count_q, count_d;
   logic [63:0] total_q, total_d;

   always_comb begin
      count_d = count_q;
      total_d = total_q;
      if (clear_i) begin
         count_d = '0;
         total_d = '0;
      end else if (accept_i) begin
         count_d = count_q + 32'd1;
         if (!timeout_i) begin
            total_d = total_q + {32'd0, cycles_i};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         total_q <= '0;
      end else begin
         count_q <= count_d;
         total_q <= total_d;
      end
   end

   assign test_count_o    = count_q;
   assign total_latency_o = total_q;

endmodule

// File: rtl/decoder_round_scheduler.sv
// rtl/decoder_round_scheduler.sv - Syndrome layer assembler and decoder sequencer
// Loads all measurement layers, pulses the decoder, then reports its result or a timeout.
module decoder_round_scheduler
   import helios_sched_pkg::*;
#(
   parameter int CODE_DISTANCE_X         = 15,
   parameter int CODE_DISTANCE_Z         = 14,
   parameter int MEASUREMENT_ROUNDS      = 15,
   parameter int ITERATION_COUNTER_WIDTH = ITER_W,
   parameter int TIMEOUT_CYCLES          = 4096,
   localparam int LAYER_BITS = layer_bits(CODE_DISTANCE_X, CODE_DISTANCE_Z),
   localparam int PU_COUNT   = pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z, MEASUREMENT_ROUNDS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   input  logic                               stats_clear,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic [LAYER_BITS-1:0]              s_data,
   output logic                               dec_new_round_start,
   output logic [PU_COUNT-1:0]                dec_measurements,
   input  logic                               dec_result_valid,
   input  logic [ITERATION_COUNTER_WIDTH-1:0] dec_iteration_counter,
   input  logic [31:0]                        dec_cycle_counter,
   output logic                               r_valid,
   input  logic                               r_ready,
   output logic [31:0]                        r_test_id,
   output logic [31:0]                        r_cycles,
   output logic [ITERATION_COUNTER_WIDTH-1:0] r_iterations,
   output logic                               r_timeout,
   output logic [63:0]                        total_latency,
   output logic [31:0]                        test_count,
   output logic                               busy
);

   localparam int LCW = $clog2(MEASUREMENT_ROUNDS + 1);
   localparam int WCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [LCW-1:0] LAST_LAYER = LCW'(MEASUREMENT_ROUNDS - 1);
   localparam logic [WCW-1:0] LAST_WAIT  = WCW'(TIMEOUT_CYCLES - 1);

   sched_state_t        state_q;
   logic [LCW-1:0]      layer_cnt_q;
   logic [WCW-1:0]      wait_cnt_q;
   logic                rv_prev_q;
   logic                s_ready_q;
   logic                start_q;
   logic                r_valid_q;
   logic [PU_COUNT-1:0] meas_q;
   sched_report_t       rpt_q;
   logic [31:0]         test_count_w;
   logic                rv_edge;
   logic                report_accept;

   // Only a fresh rising edge counts, so a level left high by the last test is ignored.
   assign rv_edge       = dec_result_valid & ~rv_prev_q;
   assign report_accept = r_valid_q & r_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         layer_cnt_q <= '0;
         wait_cnt_q  <= '0;
         rv_prev_q   <= 1'b0;
         s_ready_q   <= 1'b0;
         start_q     <= 1'b0;
         r_valid_q   <= 1'b0;
         meas_q      <= '0;
         rpt_q       <= '0;
      end else begin
         start_q   <= 1'b0;
         rv_prev_q <= dec_result_valid;
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q     <= LOAD;
                  layer_cnt_q <= '0;
                  s_ready_q   <= 1'b1;
               end
            end
            LOAD: begin
               if (s_valid && s_ready_q) begin
                  meas_q[layer_cnt_q*LAYER_BITS +: LAYER_BITS] <= s_data;
                  layer_cnt_q <= layer_cnt_q + 1'b1;
                  if (layer_cnt_q == LAST_LAYER) begin
                     state_q   <= START;
                     s_ready_q <= 1'b0;
                     start_q   <= 1'b1;
                  end
               end
            end
            START: begin
               wait_cnt_q <= '0;
               state_q    <= WAIT;
            end
            WAIT: begin
               if (rv_edge) begin
                  rpt_q     <= '{test_id: test_count_w + 32'd1, cycles: dec_cycle_counter,
                                 iterations: dec_iteration_counter, timeout: 1'b0};
                  r_valid_q <= 1'b1;
                  state_q   <= REPORT;
               end else if (wait_cnt_q == LAST_WAIT) begin
                  rpt_q     <= '{test_id: test_count_w + 32'd1, cycles: 32'(TIMEOUT_CYCLES),
                                 iterations: '0, timeout: 1'b1};
                  r_valid_q <= 1'b1;
                  state_q   <= REPORT;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            REPORT: begin
               if (r_ready) begin
                  r_valid_q   <= 1'b0;
                  layer_cnt_q <= '0;
                  s_ready_q   <= enable;
                  state_q     <= enable ? LOAD : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   latency_stats_accumulator u_stats (
      .clk             (clk),
      .reset           (reset),
      .clear_i         (stats_clear),
      .accept_i        (report_accept),
      .timeout_i       (rpt_q.timeout),
      .cycles_i        (rpt_q.cycles),
      .test_count_o    (test_count_w),
      .total_latency_o (total_latency)
   );

   assign s_ready             = s_ready_q;
   assign dec_new_round_start = start_q;
   assign dec_measurements    = meas_q;
   assign r_valid             = r_valid_q;
   assign r_test_id           = rpt_q.test_id;
   assign r_cycles            = rpt_q.cycles;
   assign r_iterations        = rpt_q.iterations;
   assign r_timeout           = rpt_q.timeout;
   assign test_count          = test_count_w;
   assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_round_scheduler.sv
// tb/tb_decoder_round_scheduler.sv - Self-checking bench for decoder_round_scheduler
module tb_decoder_round_scheduler;

   localparam int LB = 210;
   localparam int MR = 15;
   localparam int PU = LB * MR;
   localparam int TO = 64;

   logic          clk, reset, enable, stats_clear;
   logic          s_valid, s_ready;
   logic [LB-1:0] s_data;
   logic          dec_new_round_start;
   logic [PU-1:0] dec_measurements;
   logic          dec_result_valid;
   logic [7:0]    dec_iteration_counter;
   logic [31:0]   dec_cycle_counter;
   logic          r_valid, r_ready;
   logic [31:0]   r_test_id, r_cycles;
   logic [7:0]    r_iterations;
   logic          r_timeout;
   logic [63:0]   total_latency;
   logic [31:0]   test_count;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [PU-1:0]   exp_meas;
   bit              load_ok, early_pulse;
   int              pulse_count;
   longint unsigned model_total;
   int unsigned     model_count;

   decoder_round_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .enable(enable), .stats_clear(stats_clear),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .dec_new_round_start(dec_new_round_start), .dec_measurements(dec_measurements),
      .dec_result_valid(dec_result_valid), .dec_iteration_counter(dec_iteration_counter),
      .dec_cycle_counter(dec_cycle_counter),
      .r_valid(r_valid), .r_ready(r_ready), .r_test_id(r_test_id), .r_cycles(r_cycles),
      .r_iterations(r_iterations), .r_timeout(r_timeout),
      .total_latency(total_latency), .test_count(test_count), .busy(busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Stimulus only: stream MR layers and remember what the vector should hold.
   task automatic send_layers(input bit pattern3, input bit gaps);
      logic [LB-1:0] layer;
      int guard;
      load_ok = 1;
      early_pulse = 0;
      for (int l = 0; l < MR; l++) begin
         for (int k = 0; k < LB; k++) layer[k] = pattern3 ? (l == 3) : 1'($urandom_range(0, 1));
         if (gaps) begin
            s_valid = 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         s_valid = 1;
         s_data  = layer;
         guard   = 0;
         while (!s_ready && guard < 100) begin @(posedge clk); #1; guard++; end
         if (!s_ready) load_ok = 0;
         @(posedge clk); #1;
         exp_meas[l*LB +: LB] = layer;
         if (l < MR - 1 && dec_new_round_start) early_pulse = 1;
      end
      s_valid = 0;
   endtask

   // Decoder model: raise result_valid lat cycles after the start pulse (lat=0: never).
   task automatic run_decoder(input int lat, input logic [31:0] cyc, input logic [7:0] it,
                              output int seen);
      int n = 0;
      pulse_count = dec_new_round_start ? 1 : 0;
      seen = -1;
      while (n < 200) begin
         @(posedge clk); #1;
         n++;
         if (dec_new_round_start) pulse_count++;
         if (r_valid) begin
            seen = n;
            break;
         end
         if (n == lat) begin
            dec_result_valid      = 1;
            dec_cycle_counter     = cyc;
            dec_iteration_counter = it;
         end
      end
   endtask

   task automatic accept_report(input bit en, input bit clr, input bit was_to, input logic [31:0] cyc);
      enable      = en;
      stats_clear = clr;
      r_ready     = 1;
      @(posedge clk); #1;
      r_ready          = 0;
      stats_clear      = 0;
      dec_result_valid = 0;
      if (clr) begin
         model_count = 0;
         model_total = 0;
      end else begin
         model_count++;
         if (!was_to) model_total += 64'(cyc);
      end
   endtask

   task automatic test_reset;
      logic [172:0] outs;
      reset = 0; enable = 0; stats_clear = 0; s_valid = 0; s_data = '0; r_ready = 0;
      dec_result_valid = 0; dec_iteration_counter = 0; dec_cycle_counter = 0;
      model_total = 0; model_count = 0;
      @(posedge clk); #1;
      outs = {s_ready, dec_new_round_start, r_valid, r_test_id, r_cycles, r_iterations, r_timeout,
              total_latency, test_count, busy};
      checks++;
      if (outs !== '0 || dec_measurements !== '0) begin
         failures++;
         $display("FAIL reset_initial got=%h meas_ones=%0d required=0", outs, $countones(dec_measurements));
      end
      reset = 1; enable = 1;
      @(posedge clk); #1;
      for (int l = 0; l < 5; l++) begin
         s_valid = 1;
         s_data  = {7{$urandom()}};
         @(posedge clk); #1;
      end
      #2 reset = 0;
      #1;
      outs = {s_ready, dec_new_round_start, r_valid, r_test_id, r_cycles, r_iterations, r_timeout,
              total_latency, test_count, busy};
      checks++;
      if (outs !== '0 || dec_measurements !== '0) begin
         failures++;
         $display("FAIL reset_mid_load got=%h meas_ones=%0d required=0", outs, $countones(dec_measurements));
      end
      s_valid = 0;
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      checks++;
      if ({busy, s_ready} !== 2'b11) begin
         failures++;
         $display("FAIL reset_to_load busy_sready=%b required=11", {busy, s_ready});
      end
   endtask

   task automatic test_basic;
      int seen;
      send_layers(1, 0);
      checks++;
      if ({load_ok, early_pulse} !== 2'b10) begin
         failures++;
         $display("FAIL basic_load ok_early=%b required=10", {load_ok, early_pulse});
      end
      checks++;
      if ({dec_new_round_start, s_ready} !== 2'b10) begin
         failures++;
         $display("FAIL basic_start_latency start_sready=%b required=10", {dec_new_round_start, s_ready});
      end
      checks++;
      if (dec_measurements !== exp_meas) begin
         failures++;
         $display("FAIL basic_meas diff_bits=%0d required=0", $countones(dec_measurements ^ exp_meas));
      end
      run_decoder(40, 32'd40, 8'd6, seen);
      checks++;
      if (seen !== 41 || pulse_count !== 1) begin
         failures++;
         $display("FAIL basic_report_latency got=%0d pulses=%0d required=41 pulses=1", seen, pulse_count);
      end
      checks++;
      if ({r_test_id, r_cycles, r_iterations, r_timeout} !== {32'd1, 32'd40, 8'd6, 1'b0}) begin
         failures++;
         $display("FAIL basic_report id=%0d cyc=%0d it=%0d to=%b required id=1 cyc=40 it=6 to=0",
                  r_test_id, r_cycles, r_iterations, r_timeout);
      end
      accept_report(1, 0, 0, 32'd40);
      checks++;
      if (total_latency !== model_total || test_count !== model_count) begin
         failures++;
         $display("FAIL basic_stats total=%0d count=%0d required total=%0d count=%0d",
                  total_latency, test_count, model_total, model_count);
      end
   endtask

   task automatic test_stale_level;
      int seen = -1;
      logic [7:0] it;
      it = 8'($urandom());
      dec_result_valid = 1; dec_cycle_counter = 32'd999; dec_iteration_counter = 8'd77;
      send_layers(0, 1);
      checks++;
      if (dec_new_round_start !== 1'b1 || dec_measurements !== exp_meas) begin
         failures++;
         $display("FAIL stale_load start=%b diff_bits=%0d required start=1 diff=0",
                  dec_new_round_start, $countones(dec_measurements ^ exp_meas));
      end
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (r_valid) begin
            seen = n;
            break;
         end
         if (n == 2) dec_result_valid = 0;
         if (n == 30) begin
            dec_result_valid = 1; dec_cycle_counter = 32'd30; dec_iteration_counter = it;
         end
      end
      checks++;
      if (seen !== 31) begin
         failures++;
         $display("FAIL stale_latency got=%0d required=31", seen);
      end
      checks++;
      if ({r_test_id, r_cycles, r_iterations, r_timeout} !== {32'(model_count + 1), 32'd30, it, 1'b0}) begin
         failures++;
         $display("FAIL stale_report id=%0d cyc=%0d it=%0d to=%b required id=%0d cyc=30 it=%0d to=0",
                  r_test_id, r_cycles, r_iterations, r_timeout, model_count + 1, it);
      end
      accept_report(1, 0, 0, 32'd30);
   endtask

   task automatic test_timeout;
      int lats[3] = '{0, TO, TO + 1};
      int seen, exp_lat;
      bit resp;
      logic [31:0] cyc;
      logic [7:0] it;
      foreach (lats[i]) begin
         cyc = $urandom_range(1, 1000); it = 8'($urandom_range(1, 255));
         dec_cycle_counter = cyc; dec_iteration_counter = it;
         send_layers(0, 0);
         run_decoder(lats[i], cyc, it, seen);
         resp    = (lats[i] >= 1 && lats[i] <= TO);
         exp_lat = resp ? lats[i] + 1 : TO + 1;
         checks++;
         if (seen !== exp_lat || pulse_count !== 1) begin
            failures++;
            $display("FAIL timeout_latency lat=%0d got=%0d pulses=%0d required=%0d pulses=1",
                     lats[i], seen, pulse_count, exp_lat);
         end
         checks++;
         if ({r_test_id, r_cycles, r_iterations, r_timeout} !==
             {32'(model_count + 1), resp ? cyc : 32'(TO), resp ? it : 8'd0, !resp}) begin
            failures++;
            $display("FAIL timeout_report lat=%0d id=%0d cyc=%0d it=%0d to=%b required to=%b",
                     lats[i], r_test_id, r_cycles, r_iterations, r_timeout, !resp);
         end
         accept_report(1, 0, !resp, cyc);
         checks++;
         if (total_latency !== model_total || test_count !== model_count) begin
            failures++;
            $display("FAIL timeout_stats total=%0d count=%0d required total=%0d count=%0d",
                     total_latency, test_count, model_total, model_count);
         end
      end
   endtask

   task automatic test_backpressure;
      int seen, lat;
      logic [31:0] cyc;
      logic [7:0] it;
      logic [72:0] exp_r;
      lat = $urandom_range(1, 20); cyc = $urandom(); it = 8'($urandom());
      send_layers(0, 0);
      run_decoder(lat, cyc, it, seen);
      checks++;
      if (seen !== lat + 1) begin
         failures++;
         $display("FAIL bp_latency got=%0d required=%0d", seen, lat + 1);
      end
      exp_r = {32'(model_count + 1), cyc, it, 1'b0};
      for (int c = 0; c <= 10; c++) begin
         checks++;
         if (r_valid !== 1'b1 || s_ready !== 1'b0 ||
             {r_test_id, r_cycles, r_iterations, r_timeout} !== exp_r) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d rv=%b srdy=%b fields=%h required rv=1 srdy=0 fields=%h",
                     c, r_valid, s_ready, {r_test_id, r_cycles, r_iterations, r_timeout}, exp_r);
         end
         if (c < 10) begin
            dec_result_valid  = ~dec_result_valid;
            dec_cycle_counter = $urandom();
            @(posedge clk); #1;
         end
      end
      accept_report(0, 0, 0, cyc);
      @(posedge clk); #1;
      checks++;
      if ({busy, s_ready, r_valid} !== 3'b000) begin
         failures++;
         $display("FAIL bp_to_idle busy_srdy_rv=%b required=000", {busy, s_ready, r_valid});
      end
   endtask

   task automatic test_stats_clear;
      int cycs[4] = '{30, 30, 40, 55};
      int seen, lat;
      logic [7:0] it;
      enable = 1;
      @(posedge clk); #1;
      stats_clear = 1;
      @(posedge clk); #1;
      stats_clear = 0;
      model_count = 0; model_total = 0;
      checks++;
      if ({test_count, total_latency} !== '0 || {busy, s_ready} !== 2'b11) begin
         failures++;
         $display("FAIL clear_alone count=%0d total=%0d busy_srdy=%b required 0 0 11",
                  test_count, total_latency, {busy, s_ready});
      end
      for (int i = 0; i < 4; i++) begin
         lat = $urandom_range(1, 20); it = 8'($urandom());
         send_layers(0, 0);
         run_decoder(lat, 32'(cycs[i]), it, seen);
         checks++;
         if (seen !== lat + 1 || {r_test_id, r_cycles, r_timeout} !== {32'(model_count + 1), 32'(cycs[i]), 1'b0}) begin
            failures++;
            $display("FAIL clear_report i=%0d lat=%0d id=%0d cyc=%0d to=%b required lat=%0d id=%0d cyc=%0d",
                     i, seen, r_test_id, r_cycles, r_timeout, lat + 1, model_count + 1, cycs[i]);
         end
         if (i == 3) begin
            checks++;
            if (total_latency !== 64'd100 || test_count !== 32'd3) begin
               failures++;
               $display("FAIL clear_pre total=%0d count=%0d required total=100 count=3",
                        total_latency, test_count);
            end
            accept_report(1, 1, 0, 32'(cycs[i]));
         end else begin
            accept_report(1, 0, 0, 32'(cycs[i]));
         end
      end
      checks++;
      if (total_latency !== model_total || test_count !== model_count) begin
         failures++;
         $display("FAIL clear_with_accept total=%0d count=%0d required total=%0d count=%0d",
                  total_latency, test_count, model_total, model_count);
      end
   endtask

   task automatic test_random;
      int seen, lat, exp_lat;
      bit resp;
      logic [31:0] cyc;
      logic [7:0] it;
      for (int t = 0; t < 6; t++) begin
         lat = $urandom_range(1, TO + 8); cyc = $urandom(); it = 8'($urandom());
         send_layers(0, 1);
         checks++;
         if (dec_measurements !== exp_meas || early_pulse !== 1'b0) begin
            failures++;
            $display("FAIL rand_meas t=%0d diff_bits=%0d early=%b required 0 0",
                     t, $countones(dec_measurements ^ exp_meas), early_pulse);
         end
         run_decoder(lat, cyc, it, seen);
         resp    = (lat <= TO);
         exp_lat = resp ? lat + 1 : TO + 1;
         checks++;
         if (seen !== exp_lat || pulse_count !== 1 ||
             {r_test_id, r_cycles, r_iterations, r_timeout} !==
             {32'(model_count + 1), resp ? cyc : 32'(TO), resp ? it : 8'd0, !resp}) begin
            failures++;
            $display("FAIL rand_report t=%0d lat=%0d seen=%0d id=%0d cyc=%0d it=%0d to=%b required seen=%0d id=%0d to=%b",
                     t, lat, seen, r_test_id, r_cycles, r_iterations, r_timeout, exp_lat, model_count + 1, !resp);
         end
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         accept_report(1, 0, !resp, cyc);
         checks++;
         if (total_latency !== model_total || test_count !== model_count) begin
            failures++;
            $display("FAIL rand_stats t=%0d total=%0d count=%0d required total=%0d count=%0d",
                     t, total_latency, test_count, model_total, model_count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stale_level();
      test_timeout();
      test_backpressure();
      test_stats_clear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
